bsg_gateway_tag_serializer: RTL and testbench

- Bit-serial transmit stage for the gateway's tag path, running on the microblaze clock domain.
- Accepts fixed-width tag packets over a valid/ready handshake from the tag packet source and drives the ASIC tag ring pins (TDI/TMS).
- Generates the ring-flush sequence after reset, frames each packet with a start bit and an inter-packet gap, and raises a sticky done flag once a programmed number of packets has left the pins.
- done_o feeds the comm-link reset gating when tag-driven bring-up is selected.

---
 rtl/bsg_gateway_tag_serializer_if.sv | 15 +
 rtl/bsg_gateway_tag_serializer.sv | 149 ++++++++++++++
 tb/tb_bsg_gateway_tag_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bsg_gateway_tag_serializer_if.sv
// rtl/bsg_gateway_tag_serializer_if.sv - tag packet handshake between packet source and serializer
//
// valid_i : packet available (source -> serializer)
// data_i  : packet payload, bit 0 transmitted first (source -> serializer)
// ready_o : serializer can accept a packet (serializer -> source)
interface bsg_gateway_tag_serializer_if #(
    parameter int ring_width_p = 36
);
    logic                    valid_i;
    logic [ring_width_p-1:0] data_i;
    logic                    ready_o;

    modport master (output valid_i, output data_i, input  ready_o);
    modport slave  (input  valid_i, input  data_i, output ready_o);
endinterface

// File: rtl/bsg_gateway_tag_serializer.sv
// rtl/bsg_gateway_tag_serializer.sv - bit-serial transmit stage driving the ASIC tag ring pins
//
// Flushes the ring (tms_o=1) after reset, then frames each accepted packet as
// start bit, ring_width_p payload bits (LSB first) and a gap_cycles_p idle gap.
//
// clk_i       : tag clock, rising edge
// reset_n_i   : asynchronous active-low reset
// tag_if      : slave side of the packet handshake (valid_i, data_i, ready_o)
// tdi_o       : serial data to tag ring
// tms_o       : ring flush strobe
// busy_o      : high whenever not IDLE
// done_o      : sticky, num_packets_p packets fully shifted
// pkt_count_o : packets fully shifted, saturating at 255
module bsg_gateway_tag_serializer #(
    parameter int ring_width_p   = 36,
    parameter int flush_cycles_p = 64,
    parameter int gap_cycles_p   = 4,
    parameter int num_packets_p  = 12
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    bsg_gateway_tag_serializer_if.slave       tag_if,
    output logic                              tdi_o,
    output logic                              tms_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [7:0]                        pkt_count_o
);

    localparam int flush_w_lp = $clog2(flush_cycles_p + 1);
    localparam int idx_w_lp   = $clog2(ring_width_p + 1);
    localparam int gap_w_lp   = $clog2(gap_cycles_p + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_START,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e                  state_q, state_n;
    logic [flush_w_lp-1:0]   flush_cnt_q, flush_cnt_n;
    logic [idx_w_lp-1:0]     idx_q, idx_n;
    logic [gap_w_lp-1:0]     gap_cnt_q, gap_cnt_n;
    logic [ring_width_p-1:0] sr_q, sr_n;
    logic [7:0]              pkt_count_n;
    logic                    done_n;
    logic                    tdi_n;
    logic                    tms_n;
    logic                    busy_n;

    // ready is a pure decode of the state register, never of valid_i
    assign tag_if.ready_o = (state_q == S_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            sr_q        <= '0;
            pkt_count_o <= 8'd0;
            done_o      <= 1'b0;
            tdi_o       <= 1'b0;
            tms_o       <= 1'b1;
            busy_o      <= 1'b1;
        end else begin
            state_q     <= state_n;
            flush_cnt_q <= flush_cnt_n;
            idx_q       <= idx_n;
            gap_cnt_q   <= gap_cnt_n;
            sr_q        <= sr_n;
            pkt_count_o <= pkt_count_n;
            done_o      <= done_n;
            tdi_o       <= tdi_n;
            tms_o       <= tms_n;
            busy_o      <= busy_n;
        end
    end

    // Pin outputs are registered, so tdi_n is the value for the state being
    // entered: the start bit is loaded on accept, payload bit k on the edge
    // that enters SHIFT index k.
    always_comb begin
        state_n     = state_q;
        flush_cnt_n = flush_cnt_q;
        idx_n       = idx_q;
        gap_cnt_n   = gap_cnt_q;
        sr_n        = sr_q;
        pkt_count_n = pkt_count_o;
        done_n      = done_o;
        tdi_n       = 1'b0;

        case (state_q)
            S_FLUSH: begin
                // counter reaches flush_cycles_p after that many edges in FLUSH
                if (flush_cnt_q == flush_w_lp'(flush_cycles_p)) begin
                    state_n = S_IDLE;
                end else begin
                    flush_cnt_n = flush_cnt_q + flush_w_lp'(1);
                end
            end
            S_IDLE: begin
                if (tag_if.valid_i) begin
                    sr_n    = tag_if.data_i;
                    state_n = S_START;
                    tdi_n   = 1'b1;
                end
            end
            S_START: begin
                state_n = S_SHIFT;
                idx_n   = '0;
                tdi_n   = sr_q[0];
                sr_n    = sr_q >> 1;
            end
            S_SHIFT: begin
                if (idx_q == idx_w_lp'(ring_width_p - 1)) begin
                    state_n   = S_GAP;
                    gap_cnt_n = '0;
                end else begin
                    idx_n = idx_q + idx_w_lp'(1);
                    tdi_n = sr_q[0];
                    sr_n  = sr_q >> 1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gap_w_lp'(gap_cycles_p - 1)) begin
                    state_n = S_IDLE;
                    if (pkt_count_o != 8'hFF) begin
                        pkt_count_n = pkt_count_o + 8'd1;
                    end
                    if (pkt_count_n == 8'(num_packets_p)) begin
                        done_n = 1'b1;
                    end
                end else begin
                    gap_cnt_n = gap_cnt_q + gap_w_lp'(1);
                end
            end
            default: begin
                state_n = S_FLUSH;
            end
        endcase

        tms_n  = (state_n == S_FLUSH);
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_bsg_gateway_tag_serializer.sv
// tb/tb_bsg_gateway_tag_serializer.sv - directed self-checking bench for bsg_gateway_tag_serializer
module tb_bsg_gateway_tag_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bsg_gateway_tag_serializer_if #(.ring_width_p(36)) if_a();
    bsg_gateway_tag_serializer_if #(.ring_width_p(8))  if_b();

    logic       tdi_a, tms_a, busy_a, done_a;
    logic [7:0] cnt_a;
    logic       tdi_b, tms_b, busy_b, done_b;
    logic [7:0] cnt_b;

    bsg_gateway_tag_serializer #(
        .ring_width_p(36), .flush_cycles_p(64), .gap_cycles_p(4), .num_packets_p(12)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .tag_if(if_a),
        .tdi_o(tdi_a), .tms_o(tms_a), .busy_o(busy_a), .done_o(done_a), .pkt_count_o(cnt_a)
    );

    bsg_gateway_tag_serializer #(
        .ring_width_p(8), .flush_cycles_p(64), .gap_cycles_p(1), .num_packets_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .tag_if(if_b),
        .tdi_o(tdi_b), .tms_o(tms_b), .busy_o(busy_b), .done_o(done_b), .pkt_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called right after rst_n rises at a negedge; counts negedge samples with tms high.
    task automatic flush_check();
        int n;
        n = 0;
        @(negedge clk);
        while (tms_a && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("flush_len", n, 64);
        check("flush_ready", if_a.ready_o, 1);
        check("flush_busy", busy_a, 0);
        check("flush_tdi", tdi_a, 0);
    endtask

    // Offers one packet at a negedge, samples the whole frame, and returns
    // positioned on the negedge where ready should be back.
    task automatic send(input bit sel, input logic [35:0] d, input bit hold,
                        input logic [35:0] d_after, output int waited);
        int w, g;
        logic [63:0] got, exp;
        w = sel ? 8 : 36;
        g = sel ? 1 : 4;
        waited = 0;
        while (!(sel ? if_b.ready_o : if_a.ready_o) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("ready_wait", sel ? if_b.ready_o : if_a.ready_o, 1);
        if (sel) begin
            if_b.valid_i = 1'b1;
            if_b.data_i  = d[7:0];
        end else begin
            if_a.valid_i = 1'b1;
            if_a.data_i  = d;
        end
        @(posedge clk);
        #1;
        if (sel) begin
            if (!hold) if_b.valid_i = 1'b0;
            if_b.data_i = d_after[7:0];
        end else begin
            if (!hold) if_a.valid_i = 1'b0;
            if_a.data_i = d_after;
        end
        got = '0;
        exp = '0;
        exp[0] = 1'b1;
        for (int j = 0; j < w; j++) exp[1+j] = d[j];
        for (int i = 0; i < 1 + w + g; i++) begin
            @(negedge clk);
            got[i] = sel ? tdi_b : tdi_a;
        end
        check("frame", got, exp);
        @(negedge clk);
        check("ready_after", sel ? if_b.ready_o : if_a.ready_o, 1);
        check("busy_after", sel ? busy_b : busy_a, 0);
    endtask

    initial begin
        int wt;
        logic [35:0] p;
        if_a.valid_i = 1'b0;
        if_a.data_i  = '0;
        if_b.valid_i = 1'b0;
        if_b.data_i  = '0;

        repeat (3) @(negedge clk);
        check("rst_tms", tms_a, 1);
        check("rst_tdi", tdi_a, 0);
        check("rst_ready", if_a.ready_o, 0);
        check("rst_busy", busy_a, 1);
        check("rst_done", done_a, 0);
        check("rst_cnt", cnt_a, 0);

        rst_n = 1'b1;
        flush_check();

        // single packet; data_i is scrambled after accept and must not leak into the frame
        send(1'b0, 36'h0_0000_0005, 1'b0, 36'hF_FFFF_FFF0, wt);
        check("single_cnt", cnt_a, 1);
        check("single_done", done_a, 0);
        repeat (5) @(negedge clk);
        check("no_extra_xfer", cnt_a, 1);
        check("idle_ready", if_a.ready_o, 1);

        // back-to-back with valid held high; packet count 12 is reached on the 11th here
        for (int k = 0; k < 12; k++) begin
            p = k[0] ? 36'h5_5555_5555 : 36'hA_AAAA_AAAA;
            send(1'b0, p, 1'b1, ~p, wt);
            if (k > 0) check("b2b_wait", wt, 0);
            check("b2b_cnt", cnt_a, 2 + k);
            check("b2b_done", done_a, (2 + k) >= 12);
        end

        // valid is still high, so another packet is accepted now; reset it mid-SHIFT
        @(posedge clk);
        #1;
        if_a.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_done", done_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tms", tms_a, 1);
        check("mid_rst_tdi", tdi_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_cnt", cnt_a, 0);
        check("mid_rst_ready", if_a.ready_o, 0);
        check("mid_rst_busy", busy_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        flush_check();
        send(1'b0, 36'h9_1234_5678, 1'b0, 36'h0_0000_0000, wt);
        check("post_rst_cnt", cnt_a, 1);
        check("post_rst_done", done_a, 0);

        // narrow instance: 10-cycle frame, done after the first packet
        check("b_tms", tms_b, 0);
        check("b_done_pre", done_b, 0);
        check("b_cnt_pre", cnt_b, 0);
        send(1'b1, 36'h0_0000_00C3, 1'b0, 36'h0_0000_003C, wt);
        check("b_cnt", cnt_b, 1);
        check("b_done", done_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
